// File: rtl/vga_scan_if.sv
// Bundles the compositor's sprite/background inputs and its VGA timing and colour outputs.
// The compositor uses the master modport; the sprite side and the DAC use the slave modport.
interface vga_scan_if #(
    parameter int unsigned NUM_SPRITES = 4
);
    logic [24*NUM_SPRITES-1:0] sprite_rgb_i;
    logic                      bg_we_i;
    logic [23:0]               bg_data_i;
    logic [31:0]               x_pos_o;
    logic [31:0]               y_pos_o;
    logic                      pix_clk_o;
    logic                      hsync_o;
    logic                      vsync_o;
    logic                      blank_n_o;
    logic [23:0]               RGB_o;
    logic                      vblank_o;
    logic [31:0]               frame_cnt_o;

    modport master (
        input  sprite_rgb_i, bg_we_i, bg_data_i,
        output x_pos_o, y_pos_o, pix_clk_o, hsync_o, vsync_o,
               blank_n_o, RGB_o, vblank_o, frame_cnt_o
    );

    modport slave (
        output sprite_rgb_i, bg_we_i, bg_data_i,
        input  x_pos_o, y_pos_o, pix_clk_o, hsync_o, vsync_o,
               blank_n_o, RGB_o, vblank_o, frame_cnt_o
    );
endinterface

// File: rtl/vga_scan_compositor.sv
// VGA raster scanner with a two-stage output pipeline that composites prioritised
// sprite colours over a programmable background. Pixel rate is half the clk rate.
module vga_scan_compositor #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter logic [23:0] BG_RESET    = 24'h202020,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_scan_if.master bus
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic          pix_en;
    logic [HW-1:0] h_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_nxt;
    logic          h_last;
    logic          v_last;

    logic          s1_active_c;
    logic          s1_hs_c;
    logic          s1_vs_c;
    logic          s1_active;
    logic          s1_hs;
    logic          s1_vs;

    logic          hsync_q;
    logic          vsync_q;
    logic          blank_n_q;
    logic          vblank_q;
    logic [23:0]   rgb_q;
    logic [23:0]   bg_q;
    logic [23:0]   comp_c;
    logic [31:0]   frame_q;

    // Raster counter successors; v advances only when the line wraps.
    always_comb begin
        h_last = (32'(h_cnt) == H_TOTAL - 1);
        v_last = (32'(v_cnt) == V_TOTAL - 1);
        h_nxt  = h_last ? '0 : h_cnt + HW'(1);
        v_nxt  = v_cnt;
        if (h_last) begin
            v_nxt = v_last ? '0 : v_cnt + VW'(1);
        end
    end

    // Stage-1 decode of the current raster position.
    always_comb begin
        s1_active_c = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
        s1_hs_c     = !((32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END));
        s1_vs_c     = !((32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END));
    end

    // Priority mux: walking downwards leaves the lowest opaque index as the winner.
    always_comb begin
        comp_c = bg_q;
        for (int k = int'(NUM_SPRITES) - 1; k >= 0; k--) begin
            if (bus.sprite_rgb_i[24*k +: 24] != 24'h000000) begin
                comp_c = bus.sprite_rgb_i[24*k +: 24];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en    <= 1'b0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            vblank_q  <= 1'b0;
            frame_q   <= 32'd0;
            bg_q      <= BG_RESET;
            s1_active <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= 24'h000000;
        end else begin
            pix_en <= !pix_en;
            // Background writes are not tied to pixel ticks.
            if (bus.bg_we_i) begin
                bg_q <= bus.bg_data_i;
            end
            if (pix_en) begin
                h_cnt    <= h_nxt;
                v_cnt    <= v_nxt;
                vblank_q <= (32'(v_nxt) >= V_ACTIVE);
                if (h_last && v_last) begin
                    frame_q <= frame_q + 32'd1;
                end
                s1_active <= s1_active_c;
                s1_hs     <= s1_hs_c;
                s1_vs     <= s1_vs_c;
                hsync_q   <= s1_hs;
                vsync_q   <= s1_vs;
                blank_n_q <= s1_active;
                rgb_q     <= s1_active ? comp_c : 24'h000000;
            end
        end
    end

    assign bus.x_pos_o     = 32'(h_cnt);
    assign bus.y_pos_o     = 32'(v_cnt);
    assign bus.pix_clk_o   = pix_en;
    assign bus.hsync_o     = hsync_q;
    assign bus.vsync_o     = vsync_q;
    assign bus.blank_n_o   = blank_n_q;
    assign bus.RGB_o       = rgb_q;
    assign bus.vblank_o    = vblank_q;
    assign bus.frame_cnt_o = frame_q;

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Randomised bench for vga_scan_compositor using a reduced raster so whole frames fit in a short run.
// The reference model derives every expected output from the count of pixel ticks since reset.
module tb_vga_scan_compositor;

    localparam int unsigned NS = 4;
    localparam int unsigned HA = 20, HF = 3, HS = 5, HB = 4;
    localparam int unsigned VA = 12, VF = 2, VS = 3, VB = 4;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FT = HT * VT;
    localparam logic [23:0] BG = 24'h202020;

    logic clk;
    logic rst_n;

    vga_scan_if #(.NUM_SPRITES(NS)) bus ();

    vga_scan_compositor #(
        .NUM_SPRITES(NS), .BG_RESET(BG),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          m_n;
    bit          m_pe;
    bit          m_ticked;
    logic [23:0] m_bg;
    logic [23:0] m_rgb;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference model: everything is a function of n, the number of pixel ticks since reset.
    function automatic int h_of(int n);
        return n % HT;
    endfunction

    function automatic int v_of(int n);
        return (n / HT) % VT;
    endfunction

    function automatic bit act_of(int n);
        return (h_of(n) < HA) && (v_of(n) < VA);
    endfunction

    function automatic bit hs_exp(int n);
        if (n < 2) return 1'b1;
        return !((h_of(n-2) >= HA + HF) && (h_of(n-2) < HA + HF + HS));
    endfunction

    function automatic bit vs_exp(int n);
        if (n < 2) return 1'b1;
        return !((v_of(n-2) >= VA + VF) && (v_of(n-2) < VA + VF + VS));
    endfunction

    function automatic bit blank_exp(int n);
        return (n >= 2) && act_of(n-2);
    endfunction

    function automatic logic [23:0] comp_of(logic [24*NS-1:0] s, logic [23:0] bg);
        for (int k = 0; k < NS; k++) begin
            if (s[24*k +: 24] != 24'h0) return s[24*k +: 24];
        end
        return bg;
    endfunction

    task automatic model_reset();
        m_n = 0; m_pe = 1'b0; m_bg = BG; m_rgb = 24'h0; m_ticked = 1'b0;
    endtask

    // One clk edge of stimulus plus model update; returns #1 after the edge.
    task automatic advance();
        @(posedge clk);
        m_ticked = 1'b0;
        if (rst_n) begin
            if (m_pe) begin
                m_n++;
                m_ticked = 1'b1;
                m_rgb = blank_exp(m_n) ? comp_of(bus.sprite_rgb_i, m_bg) : 24'h0;
            end
            m_pe = !m_pe;
            if (bus.bg_we_i) m_bg = bus.bg_data_i;
        end
        #1;
    endtask

    task automatic run_ticks(int t);
        int got = 0;
        for (int i = 0; i < 4*t + 4 && got < t; i++) begin
            advance();
            if (m_ticked) got++;
        end
    endtask

    task automatic seek(int h, int v);
        for (int i = 0; i < 4*FT + 8; i++) begin
            if (h_of(m_n) == h && v_of(m_n) == v) return;
            advance();
        end
    endtask

    task automatic rand_sprites();
        for (int k = 0; k < NS; k++) begin
            bus.sprite_rgb_i[24*k +: 24] = ($urandom_range(0, 1) == 0) ? 24'h0 : 24'($urandom);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.sprite_rgb_i = '0;
        bus.bg_we_i = 1'b0;
        bus.bg_data_i = 24'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.pix_clk_o !== 1'b0) begin miscompares++; $display("FAIL reset_pix_clk got %b exp 0", bus.pix_clk_o); end
        vectors++; if (bus.x_pos_o !== 32'd0) begin miscompares++; $display("FAIL reset_x got %0d exp 0", bus.x_pos_o); end
        vectors++; if (bus.y_pos_o !== 32'd0) begin miscompares++; $display("FAIL reset_y got %0d exp 0", bus.y_pos_o); end
        vectors++; if ({bus.hsync_o, bus.vsync_o} !== 2'b11) begin miscompares++; $display("FAIL reset_sync got %b%b exp 11", bus.hsync_o, bus.vsync_o); end
        vectors++; if (bus.blank_n_o !== 1'b0) begin miscompares++; $display("FAIL reset_blank got %b exp 0", bus.blank_n_o); end
        vectors++; if (bus.RGB_o !== 24'h0) begin miscompares++; $display("FAIL reset_rgb got %h exp 000000", bus.RGB_o); end
        vectors++; if (bus.vblank_o !== 1'b0) begin miscompares++; $display("FAIL reset_vblank got %b exp 0", bus.vblank_o); end
        vectors++; if (bus.frame_cnt_o !== 32'd0) begin miscompares++; $display("FAIL reset_frame got %0d exp 0", bus.frame_cnt_o); end
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            advance();
            vectors++; if (bus.pix_clk_o !== m_pe) begin miscompares++; $display("FAIL start_pix_clk clk%0d got %b exp %b", i, bus.pix_clk_o, m_pe); end
            vectors++; if (bus.x_pos_o !== 32'(h_of(m_n))) begin miscompares++; $display("FAIL start_x clk%0d got %0d exp %0d", i, bus.x_pos_o, h_of(m_n)); end
            if (i == 4) begin
                vectors++; if (bus.blank_n_o !== 1'b1) begin miscompares++; $display("FAIL start_blank got %b exp 1", bus.blank_n_o); end
                vectors++; if (bus.RGB_o !== 24'h202020) begin miscompares++; $display("FAIL start_rgb got %h exp 202020", bus.RGB_o); end
            end
        end
    endtask

    task automatic test_scan();
        int ticks = 0, hs_low = 0, vs_low = 0, blank_hi = 0;
        for (int i = 0; i < 4*FT + 8 && ticks < 2*FT; i++) begin
            rand_sprites();
            bus.bg_we_i = ($urandom_range(0, 15) == 0);
            bus.bg_data_i = 24'($urandom);
            advance();
            vectors++; if (bus.pix_clk_o !== m_pe) begin miscompares++; $display("FAIL scan_pix_clk n=%0d got %b exp %b", m_n, bus.pix_clk_o, m_pe); end
            vectors++; if (bus.x_pos_o !== 32'(h_of(m_n)) || bus.y_pos_o !== 32'(v_of(m_n))) begin miscompares++; $display("FAIL scan_xy n=%0d got (%0d,%0d) exp (%0d,%0d)", m_n, bus.x_pos_o, bus.y_pos_o, h_of(m_n), v_of(m_n)); end
            vectors++; if (bus.hsync_o !== hs_exp(m_n)) begin miscompares++; $display("FAIL scan_hsync n=%0d got %b exp %b", m_n, bus.hsync_o, hs_exp(m_n)); end
            vectors++; if (bus.vsync_o !== vs_exp(m_n)) begin miscompares++; $display("FAIL scan_vsync n=%0d got %b exp %b", m_n, bus.vsync_o, vs_exp(m_n)); end
            vectors++; if (bus.blank_n_o !== blank_exp(m_n)) begin miscompares++; $display("FAIL scan_blank n=%0d got %b exp %b", m_n, bus.blank_n_o, blank_exp(m_n)); end
            vectors++; if (bus.RGB_o !== m_rgb) begin miscompares++; $display("FAIL scan_rgb n=%0d got %h exp %h", m_n, bus.RGB_o, m_rgb); end
            vectors++; if (bus.vblank_o !== (v_of(m_n) >= VA)) begin miscompares++; $display("FAIL scan_vblank n=%0d got %b exp %b", m_n, bus.vblank_o, v_of(m_n) >= VA); end
            vectors++; if (bus.frame_cnt_o !== 32'(m_n / FT)) begin miscompares++; $display("FAIL scan_frame n=%0d got %0d exp %0d", m_n, bus.frame_cnt_o, m_n / FT); end
            if (m_ticked) begin
                ticks++;
                if (!bus.hsync_o) hs_low++;
                if (!bus.vsync_o) vs_low++;
                if (bus.blank_n_o) blank_hi++;
            end
        end
        bus.bg_we_i = 1'b0;
        vectors++; if (hs_low != 2*HS*VT) begin miscompares++; $display("FAIL hsync_width got %0d exp %0d", hs_low, 2*HS*VT); end
        vectors++; if (vs_low != 2*VS*HT) begin miscompares++; $display("FAIL vsync_width got %0d exp %0d", vs_low, 2*VS*HT); end
        vectors++; if (blank_hi != 2*HA*VA) begin miscompares++; $display("FAIL active_count got %0d exp %0d", blank_hi, 2*HA*VA); end
    endtask

    task automatic test_priority();
        seek(2, 1);
        bus.sprite_rgb_i = {24'h000000, 24'h00FF00, 24'hFF0000, 24'h000000};
        run_ticks(2);
        vectors++; if (bus.RGB_o !== 24'hFF0000 || m_rgb !== 24'hFF0000) begin miscompares++; $display("FAIL prio_s1 got %h exp ff0000", bus.RGB_o); end
        bus.sprite_rgb_i[23:0] = 24'h0000FF;
        run_ticks(1);
        vectors++; if (bus.RGB_o !== 24'h0000FF) begin miscompares++; $display("FAIL prio_s0 got %h exp 0000ff", bus.RGB_o); end
        bus.sprite_rgb_i = '0;
    endtask

    task automatic test_bg_write();
        seek(5, 3);
        if ($urandom_range(0, 1) == 1) advance();
        bus.bg_we_i = 1'b1;
        bus.bg_data_i = 24'h123456;
        advance();
        bus.bg_we_i = 1'b0;
        run_ticks(2);
        vectors++; if (bus.RGB_o !== 24'h123456 || m_rgb !== 24'h123456) begin miscompares++; $display("FAIL bg_active got %h exp 123456", bus.RGB_o); end
        seek(HA + 2, 3);
        bus.bg_we_i = 1'b1;
        bus.bg_data_i = 24'h654321;
        advance();
        bus.bg_we_i = 1'b0;
        run_ticks(2);
        vectors++; if (bus.RGB_o !== 24'h0 || bus.blank_n_o !== 1'b0) begin miscompares++; $display("FAIL bg_blanking got rgb=%h blank_n=%b exp 000000/0", bus.RGB_o, bus.blank_n_o); end
        seek(0, 4);
        run_ticks(2);
        vectors++; if (bus.RGB_o !== 24'h654321) begin miscompares++; $display("FAIL bg_next_line got %h exp 654321", bus.RGB_o); end
    endtask

    task automatic test_reset_mid();
        seek(15, 8);
        #5;
        rst_n = 1'b0;
        #1;
        vectors++; if ({bus.pix_clk_o, bus.hsync_o, bus.vsync_o, bus.blank_n_o, bus.vblank_o} !== 5'b01100) begin miscompares++; $display("FAIL mid_ctrl got %b exp 01100", {bus.pix_clk_o, bus.hsync_o, bus.vsync_o, bus.blank_n_o, bus.vblank_o}); end
        vectors++; if (bus.x_pos_o !== 32'd0 || bus.y_pos_o !== 32'd0) begin miscompares++; $display("FAIL mid_xy got (%0d,%0d) exp (0,0)", bus.x_pos_o, bus.y_pos_o); end
        vectors++; if (bus.RGB_o !== 24'h0) begin miscompares++; $display("FAIL mid_rgb got %h exp 000000", bus.RGB_o); end
        vectors++; if (bus.frame_cnt_o !== 32'd0) begin miscompares++; $display("FAIL mid_frame got %0d exp 0", bus.frame_cnt_o); end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6*HT; i++) begin
            rand_sprites();
            advance();
            vectors++; if (bus.pix_clk_o !== m_pe || bus.x_pos_o !== 32'(h_of(m_n)) || bus.y_pos_o !== 32'(v_of(m_n))) begin miscompares++; $display("FAIL post_xy n=%0d got (%0d,%0d) exp (%0d,%0d)", m_n, bus.x_pos_o, bus.y_pos_o, h_of(m_n), v_of(m_n)); end
            vectors++; if (bus.RGB_o !== m_rgb || bus.blank_n_o !== blank_exp(m_n)) begin miscompares++; $display("FAIL post_rgb n=%0d got %h exp %h", m_n, bus.RGB_o, m_rgb); end
            vectors++; if (bus.frame_cnt_o !== 32'd0) begin miscompares++; $display("FAIL post_frame got %0d exp 0", bus.frame_cnt_o); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_priority();
        test_bg_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
